ram_4x4: RTL and testbench
==========================

RAM_4X4 -- requirements
Module: ram_4x4

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL set the word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 2, SHALL set the address width; depth = 2**ADDR_WIDTH (4 words at default).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change only on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port we, input, 1 bit: write enable (1 = write, 0 = read only).
REQ-006 Port addr, input, ADDR_WIDTH bits: word address for both write and read.
REQ-007 Port din, input, DATA_WIDTH bits: write data.
REQ-008 Port dout, output, DATA_WIDTH bits: registered read data.

Function
REQ-009 Storage SHALL be 2**ADDR_WIDTH words of DATA_WIDTH bits, held in registers.
REQ-010 On a rising clk edge with rst=0 and we=1, mem[addr] SHALL be loaded with din.
REQ-011 On a rising clk edge with rst=0 and we=0, memory contents SHALL be unchanged.
REQ-012 dout SHALL be a register updated on every rising clk edge with rst=0, giving 1-cycle read latency.
REQ-013 With we=0, dout after the edge SHALL equal mem[addr] as sampled at that edge.
REQ-014 With we=1 (read-during-write, write-first), dout after the edge SHALL equal din, the newly written data.
REQ-015 dout SHALL hold its value between edges and SHALL NOT change combinationally with addr, din or we.
REQ-016 Every addr value in 0..2**ADDR_WIDTH-1 SHALL be valid; no out-of-range case exists and no wrap logic is required.
REQ-017 A write to one address SHALL NOT alter any other address.
REQ-018 Back-to-back writes on consecutive cycles, to the same or different addresses, SHALL all take effect; the last write to an address wins.
REQ-019 The block SHALL have no handshake; every cycle is accepted.

Reset
REQ-020 On a rising clk edge with rst=1, all memory words SHALL become 0 and dout SHALL become 0.
REQ-021 rst SHALL take priority over we; a write in a reset cycle SHALL be discarded.
REQ-022 Reset asserted between operations SHALL erase previously written data; a following read SHALL return 0.
REQ-023 rst SHALL have no asynchronous effect; outputs change only at the clock edge.
REQ-024 Before the first reset, memory and dout contents SHALL be undefined, and the bench SHALL NOT check them.

Verification
REQ-025 Basic write then read: rst for 1 cycle; write addr=00 din=1010, then addr=01 din=0101; then we=0, addr=00, then addr=01 -> dout after each read edge is 1010, then 0101.
REQ-026 Write-first: we=1 addr=10 din=1100 -> dout=1100 at that same edge; next cycle we=0 addr=10 -> dout=1100.
REQ-027 Isolation: write 0001, 0010, 0100, 1000 to addresses 0 to 3, then overwrite addr 2 with 1111 -> reads of addresses 0 to 3 return 0001, 0010, 1111, 1000.
REQ-028 Reset priority: with memory loaded, rst=1 and we=1 addr=01 din=0110 -> dout=0000; reads of all addresses afterwards return 0000.
REQ-029 Hold: we=0, toggle addr and din between clock edges -> dout changes only at rising edges.

Source files
------------

// File: rtl/ram_4x4.sv
// Small register-file RAM: synchronous write, registered write-first read,
// synchronous reset that clears every word and the read register.
module ram_4x4 #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      dout <= '0;
    end else if (we) begin
      // write-first: the read port returns the word being written
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: tb/tb_ram_4x4.sv
// Self-checking bench for ram_4x4: directed vector table, hold/async checks,
// then randomized traffic against a behavioural memory model.
module tb_ram_4x4;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  int checks   = 0;
  int failures = 0;

  // behavioural reference
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_dout;

  typedef struct packed {
    logic          rst;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  ram_4x4 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: dout=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // advance the model by one rising edge using the inputs present at that edge
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_dout = '0;
    end else if (we) begin
      model_mem[addr] = din;
      model_dout      = din;
    end else begin
      model_dout = model_mem[addr];
    end
  endtask

  task automatic edge_check(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check(name, dout, model_dout);
  endtask

  task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    @(negedge clk);
    rst  = r;
    we   = w;
    addr = a;
    din  = d;
  endtask

  task automatic add(input logic r, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [DW-1:0] e);
    vecs.push_back('{r, w, a, d, e});
  endtask

  initial begin
    logic [DW-1:0] held;
    rst = 1'b1; we = 1'b0; addr = '0; din = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;
    model_dout = 'x;

    // reset, basic write/read
    add(1, 0, 2'd0, 4'h0, 4'h0);
    add(0, 1, 2'd0, 4'hA, 4'hA);
    add(0, 1, 2'd1, 4'h5, 4'h5);
    add(0, 0, 2'd0, 4'h0, 4'hA);
    add(0, 0, 2'd1, 4'h0, 4'h5);
    // write-first
    add(0, 1, 2'd2, 4'hC, 4'hC);
    add(0, 0, 2'd2, 4'h3, 4'hC);
    // isolation and overwrite
    add(0, 1, 2'd0, 4'h1, 4'h1);
    add(0, 1, 2'd1, 4'h2, 4'h2);
    add(0, 1, 2'd2, 4'h4, 4'h4);
    add(0, 1, 2'd3, 4'h8, 4'h8);
    add(0, 1, 2'd2, 4'hF, 4'hF);
    add(0, 0, 2'd0, 4'h0, 4'h1);
    add(0, 0, 2'd1, 4'h0, 4'h2);
    add(0, 0, 2'd2, 4'h0, 4'hF);
    add(0, 0, 2'd3, 4'h0, 4'h8);
    // reset beats write
    add(1, 1, 2'd1, 4'h6, 4'h0);
    add(0, 0, 2'd0, 4'h0, 4'h0);
    add(0, 0, 2'd1, 4'h0, 4'h0);
    add(0, 0, 2'd2, 4'h0, 4'h0);
    add(0, 0, 2'd3, 4'h0, 4'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].din);
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("vec%0d", i), dout, vecs[i].exp);
    end

    // load a pattern, then verify dout ignores input activity between edges
    drive(0, 1, 2'd3, 4'h9); edge_check("hold_load");
    drive(0, 0, 2'd3, 4'h0); edge_check("hold_read");
    held = dout;
    for (int k = 0; k < 3; k++) begin
      #2;
      addr = AW'($urandom);
      din  = DW'($urandom);
      check($sformatf("hold_between%0d", k), dout, held);
    end
    edge_check("hold_edge");

    // reset raised mid-cycle must wait for the edge
    drive(0, 1, 2'd1, 4'h7); edge_check("async_pre");
    #2;
    rst = 1'b1; we = 1'b0;
    #1;
    check("async_no_effect", dout, 4'h7);
    edge_check("async_edge_reset");
    drive(0, 0, 2'd1, 4'h0); edge_check("async_after_read");

    // randomized traffic, occasional reset, back-to-back writes
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
            AW'($urandom), DW'($urandom));
      edge_check($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
